// File: rtl/mux_bus_regfile_pkg.sv
// Shared types and constants for the multiplexed-bus register file.
// Optional feature macro: MUXBUS_READBACK_EN.
package mux_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ARMED,
    WRITE,
    READ
  } state_t;

  localparam int         BUS_W_DEF   = 8;
  localparam logic [7:0] RD_UNMAPPED = 8'hFF;

endpackage

// File: rtl/mux_bus_regfile_if.sv
// Host strobe bundle for the multiplexed-bus register file.
// The host drives the strobes; the register file only samples them.
interface mux_bus_regfile_if;

  logic ale_i;
  logic rd_i;
  logic wr_i;

  modport master (
    output ale_i,
    output rd_i,
    output wr_i
  );

  modport slave (
    input ale_i,
    input rd_i,
    input wr_i
  );

endinterface

// File: rtl/mux_bus_regfile_sync.sv
// Multi-flop synchroniser for one async strobe.
// Emits the synchronised level plus 1-clk rise/fall pulses.
module mux_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain; keep last level for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/mux_bus_regfile.sv
// Register file on a multiplexed ALE/RD/WR host bus.
// Optional feature macro: MUXBUS_READBACK_EN (read back write regs).
module mux_bus_regfile
  import mux_bus_pkg::*;
#(
  parameter int BUS_W       = BUS_W_DEF,
  parameter int N_OUT       = 2,
  parameter int N_IN        = 2,
  parameter int OUT_BASE    = 0,
  parameter int IN_BASE     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inout  wire  [BUS_W-1:0]       bus_ad,
  mux_bus_regfile_if.slave       sbus,
  output logic [N_OUT*BUS_W-1:0] out_regs_o,
  output logic [N_OUT-1:0]       wr_stb_o,
  input  logic [N_IN*BUS_W-1:0]  in_regs_i,
  output logic [N_IN-1:0]        rd_stb_o,
  output logic                   err_o
);

  if ((OUT_BASE < IN_BASE + N_IN) &&
      (IN_BASE < OUT_BASE + N_OUT)) begin : g_bad_map
    $error("output and input address ranges overlap");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  state_t           state_q, state_d;
  logic [BUS_W-1:0] bus_q;
  logic [BUS_W-1:0] addr_q;
  logic [BUS_W-1:0] rd_data_q;
  logic [BUS_W-1:0] oregs_q [N_OUT];
  logic [N_OUT-1:0] wr_stb_q;
  logic [N_IN-1:0]  rd_stb_q;
  logic             err_q;

  logic ale_s, ale_rise, ale_fall;
  logic rd_s, rd_rise, rd_fall;
  logic wr_s, wr_rise, wr_fall;

  logic ld_addr, do_wr, do_rd, conflict;

  logic [BUS_W-1:0] out_idx, in_idx;
  logic             out_hit, in_hit;
  logic [BUS_W-1:0] rd_sel;
  logic [N_IN-1:0]  rd_stb_sel;
  logic             rd_miss;

  mux_bus_sync #(.STAGES(SYNC_STAGES)) u_ale_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sbus.ale_i),
    .lvl_o  (ale_s),
    .rise_o (ale_rise),
    .fall_o (ale_fall)
  );

  mux_bus_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sbus.rd_i),
    .lvl_o  (rd_s),
    .rise_o (rd_rise),
    .fall_o (rd_fall)
  );

  mux_bus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sbus.wr_i),
    .lvl_o  (wr_s),
    .rise_o (wr_rise),
    .fall_o (wr_fall)
  );

  // Address decode against the latched address, exact match only.
  assign out_idx = addr_q - BUS_W'(OUT_BASE);
  assign in_idx  = addr_q - BUS_W'(IN_BASE);
  assign out_hit = (addr_q >= BUS_W'(OUT_BASE)) &&
                   (out_idx < BUS_W'(N_OUT));
  assign in_hit  = (addr_q >= BUS_W'(IN_BASE)) &&
                   (in_idx < BUS_W'(N_IN));

  // Read data mux; unmapped addresses return the all-ones pattern.
  always_comb begin
    rd_sel     = BUS_W'(RD_UNMAPPED);
    rd_stb_sel = '0;
    rd_miss    = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (in_hit && in_idx == BUS_W'(k)) begin
        rd_sel        = in_regs_i[k*BUS_W +: BUS_W];
        rd_stb_sel[k] = 1'b1;
        rd_miss       = 1'b0;
      end
    end
`ifdef MUXBUS_READBACK_EN
    for (int k = 0; k < N_OUT; k++) begin
      if (out_hit && out_idx == BUS_W'(k)) begin
        rd_sel  = oregs_q[k];
        rd_miss = 1'b0;
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; ALE aborts anything, RD+WR together is a bus fault.
  always_comb begin
    state_d  = state_q;
    ld_addr  = 1'b0;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    conflict = 1'b0;
    if (ale_rise) begin
      state_d = ADDR;
    end else if (!ale_s && rd_s && wr_s &&
                 state_q inside {ARMED, WRITE, READ}) begin
      state_d  = IDLE;
      conflict = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (ale_fall) begin
            state_d = ARMED;
            ld_addr = 1'b1;
          end
        end
        ARMED: begin
          if (wr_rise) begin
            state_d = WRITE;
          end else if (rd_rise) begin
            state_d = READ;
            do_rd   = 1'b1;
          end
        end
        WRITE: begin
          if (wr_fall) begin
            state_d = ARMED;
            do_wr   = 1'b1;
          end
        end
        READ: begin
          if (rd_fall) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus sample, address latch, register writes, read snapshot, strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q     <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < N_OUT; k++) oregs_q[k] <= '0;
    end else begin
      bus_q    <= bus_ad;
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      err_q    <= conflict |
                  (do_wr & ~out_hit) |
                  (do_rd & rd_miss);
      if (ld_addr) addr_q <= bus_q;
      for (int k = 0; k < N_OUT; k++) begin
        if (do_wr && out_hit && out_idx == BUS_W'(k)) begin
          oregs_q[k]  <= bus_q;
          wr_stb_q[k] <= 1'b1;
        end
      end
      if (do_rd) begin
        rd_data_q <= rd_sel;
        rd_stb_q  <= rd_stb_sel;
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_pack
    assign out_regs_o[k*BUS_W +: BUS_W] = oregs_q[k];
  end

  assign wr_stb_o = wr_stb_q;
  assign rd_stb_o = rd_stb_q;
  assign err_o    = err_q;

  // Raw RD gates the drive so the bus is released as soon as RD drops.
  assign bus_ad = (state_q == READ && sbus.rd_i) ? rd_data_q : 'z;

endmodule

// File: tb/tb_mux_bus_regfile.sv
// Directed bench for mux_bus_regfile (default parameters).
// Released bus reads 8'h00 through the bench pulldown.
module tb_mux_bus_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_oe = 1'b0;
  logic [7:0]  host_val = 8'h00;
  logic [15:0] in_regs = 16'h0000;
  wire  [7:0]  bus_ad;
  wire  [15:0] out_regs;
  wire  [1:0]  wr_stb;
  wire  [1:0]  rd_stb;
  wire         err;

  int tests = 0;
  int failed = 0;
  int err_n = 0;
  int wr0_n = 0;
  int wr1_n = 0;
  int rd0_n = 0;
  int rd1_n = 0;

  mux_bus_regfile_if bif ();

  assign bus_ad = host_oe ? host_val : 'z;
  pulldown (bus_ad);

  mux_bus_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_ad     (bus_ad),
    .sbus       (bif.slave),
    .out_regs_o (out_regs),
    .wr_stb_o   (wr_stb),
    .in_regs_i  (in_regs),
    .rd_stb_o   (rd_stb),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err)       err_n <= err_n + 1;
    if (wr_stb[0]) wr0_n <= wr0_n + 1;
    if (wr_stb[1]) wr1_n <= wr1_n + 1;
    if (rd_stb[0]) rd0_n <= rd0_n + 1;
    if (rd_stb[1]) rd1_n <= rd1_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ale(input logic [7:0] a);
    host_oe  = 1'b1;
    host_val = a;
    tick(1);
    bif.ale_i = 1'b1;
    tick(5);
    bif.ale_i = 1'b0;
    tick(5);
  endtask

  task automatic do_wr_pulse(input logic [7:0] d);
    host_oe  = 1'b1;
    host_val = d;
    tick(1);
    bif.wr_i = 1'b1;
    tick(6);
    bif.wr_i = 1'b0;
  endtask

  task automatic test_reset;
    bif.ale_i = 1'b0;
    bif.rd_i  = 1'b0;
    bif.wr_i  = 1'b0;
    rst_n     = 1'b0;
    tick(2);
    tests++;
    if (out_regs !== 16'h0000 || wr_stb !== 2'b00 ||
        rd_stb !== 2'b00 || err !== 1'b0) begin
      failed++;
      $display("FAIL reset_outs: got %h/%b/%b/%b want 0000/00/00/0",
               out_regs, wr_stb, rd_stb, err);
    end
    tests++;
    if (bus_ad !== 8'h00) begin
      failed++;
      $display("FAIL reset_bus: got %h want 00", bus_ad);
    end
    rst_n = 1'b1;
    tick(3);
    tests++;
    if (out_regs !== 16'h0000 || err !== 1'b0) begin
      failed++;
      $display("FAIL post_reset: got %h/%b want 0000/0", out_regs, err);
    end
  endtask

  task automatic test_write;
    int e0;
    e0 = err_n;
    do_ale(8'h01);
    do_wr_pulse(8'hA5);
    tick(2);
    tests++;
    if (out_regs !== 16'h0000 || wr_stb !== 2'b00) begin
      failed++;
      $display("FAIL wr_early: got %h/%b want 0000/00", out_regs, wr_stb);
    end
    tick(1);
    tests++;
    if (out_regs !== 16'hA500 || wr_stb !== 2'b10) begin
      failed++;
      $display("FAIL wr_land: got %h/%b want a500/10", out_regs, wr_stb);
    end
    tick(1);
    tests++;
    if (wr_stb !== 2'b00) begin
      failed++;
      $display("FAIL wr_stb_width: got %b want 00", wr_stb);
    end
    tick(3);
    do_ale(8'h00);
    do_wr_pulse(8'h6B);
    tick(6);
    tests++;
    if (out_regs !== 16'hA56B || wr0_n !== 1 || wr1_n !== 1 ||
        err_n !== e0) begin
      failed++;
      $display("FAIL wr_reg0: got %h w0=%0d w1=%0d e=%0d want a56b 1 1 %0d",
               out_regs, wr0_n, wr1_n, err_n, e0);
    end
    host_oe = 1'b0;
  endtask

  task automatic test_read;
    int e0;
    e0 = err_n;
    in_regs = 16'h003C;
    do_ale(8'h02);
    host_oe  = 1'b0;
    bif.rd_i = 1'b1;
    tick(2);
    tests++;
    if (bus_ad !== 8'h00) begin
      failed++;
      $display("FAIL rd_early: got %h want 00", bus_ad);
    end
    tick(1);
    tests++;
    if (bus_ad !== 8'h3C || rd_stb !== 2'b01) begin
      failed++;
      $display("FAIL rd_first: got %h/%b want 3c/01", bus_ad, rd_stb);
    end
    tick(2);
    tests++;
    if (bus_ad !== 8'h3C || rd_stb !== 2'b00) begin
      failed++;
      $display("FAIL rd_hold: got %h/%b want 3c/00", bus_ad, rd_stb);
    end
    bif.rd_i = 1'b0;
    #1;
    tests++;
    if (bus_ad !== 8'h00) begin
      failed++;
      $display("FAIL rd_release: got %h want 00", bus_ad);
    end
    tick(5);
    tests++;
    if (rd0_n !== 1 || rd1_n !== 0 || err_n !== e0) begin
      failed++;
      $display("FAIL rd_counts: got r0=%0d r1=%0d e=%0d want 1 0 %0d",
               rd0_n, rd1_n, err_n, e0);
    end
  endtask

  task automatic test_unmapped;
    int e0;
    int w0;
    e0 = err_n;
    w0 = wr0_n + wr1_n;
    do_ale(8'h07);
    do_wr_pulse(8'h55);
    tick(6);
    tests++;
    if (err_n !== e0 + 1 || out_regs !== 16'hA56B ||
        wr0_n + wr1_n !== w0) begin
      failed++;
      $display("FAIL unmapped_wr: got e=%0d %h w=%0d want %0d a56b %0d",
               err_n, out_regs, wr0_n + wr1_n, e0 + 1, w0);
    end
    host_oe  = 1'b0;
    bif.rd_i = 1'b1;
    tick(4);
    tests++;
    if (bus_ad !== 8'hFF) begin
      failed++;
      $display("FAIL unmapped_rd: got %h want ff", bus_ad);
    end
    bif.rd_i = 1'b0;
    tick(5);
    tests++;
    if (err_n !== e0 + 2) begin
      failed++;
      $display("FAIL unmapped_rd_err: got %0d want %0d", err_n, e0 + 2);
    end
  endtask

  task automatic test_readback;
    int          e0;
    int          r0;
    logic [7:0]  exp_d;
    int          exp_e;
`ifdef MUXBUS_READBACK_EN
    exp_d = 8'h6B;
    exp_e = 0;
`else
    exp_d = 8'hFF;
    exp_e = 1;
`endif
    e0 = err_n;
    r0 = rd0_n + rd1_n;
    do_ale(8'h00);
    host_oe  = 1'b0;
    bif.rd_i = 1'b1;
    tick(4);
    tests++;
    if (bus_ad !== exp_d) begin
      failed++;
      $display("FAIL readback_data: got %h want %h", bus_ad, exp_d);
    end
    bif.rd_i = 1'b0;
    tick(5);
    tests++;
    if (err_n - e0 !== exp_e || rd0_n + rd1_n !== r0) begin
      failed++;
      $display("FAIL readback_flags: got e=%0d r=%0d want %0d %0d",
               err_n - e0, rd0_n + rd1_n, exp_e, r0);
    end
  endtask

  task automatic test_conflict;
    int e0;
    e0 = err_n;
    do_ale(8'h00);
    host_oe  = 1'b0;
    bif.rd_i = 1'b1;
    bif.wr_i = 1'b1;
    tick(4);
    tests++;
    if (bus_ad !== 8'h00) begin
      failed++;
      $display("FAIL conflict_bus: got %h want 00", bus_ad);
    end
    tick(2);
    bif.rd_i = 1'b0;
    bif.wr_i = 1'b0;
    tick(5);
    tests++;
    if (err_n !== e0 + 1 || out_regs !== 16'hA56B) begin
      failed++;
      $display("FAIL conflict: got e=%0d %h want %0d a56b",
               err_n, out_regs, e0 + 1);
    end
    do_ale(8'h00);
    do_wr_pulse(8'h11);
    tick(6);
    tests++;
    if (out_regs !== 16'hA511) begin
      failed++;
      $display("FAIL after_conflict: got %h want a511", out_regs);
    end
    host_oe = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int e0;
    int w0;
    in_regs = 16'h9A3C;
    do_ale(8'h03);
    host_oe  = 1'b0;
    bif.rd_i = 1'b1;
    tick(4);
    tests++;
    if (bus_ad !== 8'h9A) begin
      failed++;
      $display("FAIL rd_reg1: got %h want 9a", bus_ad);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus_ad !== 8'h00 || out_regs !== 16'h0000) begin
      failed++;
      $display("FAIL rst_mid_read: got %h/%h want 00/0000",
               bus_ad, out_regs);
    end
    bif.rd_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    tests++;
    if (out_regs !== 16'h0000 || wr_stb !== 2'b00 ||
        rd_stb !== 2'b00 || err !== 1'b0) begin
      failed++;
      $display("FAIL rst_release: got %h/%b/%b/%b want 0000/00/00/0",
               out_regs, wr_stb, rd_stb, err);
    end
    e0 = err_n;
    w0 = wr0_n + wr1_n;
    do_wr_pulse(8'h77);
    tick(6);
    tests++;
    if (out_regs !== 16'h0000 || wr0_n + wr1_n !== w0 ||
        err_n !== e0) begin
      failed++;
      $display("FAIL idle_wr_ignored: got %h w=%0d e=%0d want 0000 %0d %0d",
               out_regs, wr0_n + wr1_n, err_n, w0, e0);
    end
    host_oe = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_unmapped;
    test_readback;
    test_conflict;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
